// File: rtl/router_pkg.sv
// Shared router definitions: flit type encoding, type-field layout and
// requester state encoding.
package router_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } req_state_e;

  // Type field occupies the top TYPE_W bits of a flit of width dw.
  function automatic int type_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic logic opens_packet(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  function automatic logic closes_packet(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous DEPTH-deep FIFO with wrapping pointers; the front entry is
// presented combinationally on rdata.
module flit_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, and empty/count already come from reset.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/input_requester.sv
// Input-port requester: buffers flits, requests the routed output port and
// forwards one flit per grant, holding the wormhole lock until the tail.
module input_requester
  import router_pkg::*;
#(
  parameter int NR    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_FLIT,
  input  logic [NR-1:0] IN_DEST,
  output logic [NR-1:0] REQ,
  input  logic [NR-1:0] GRT,
  output logic          OUT_VALID,
  output logic [DW-1:0] OUT_FLIT,
  output logic [NR-1:0] OUT_PORT,
  output logic          ERR
);

  localparam int TMSB = type_msb(DW);

  logic [DW+NR-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  logic [DW-1:0]    front_flit;
  logic [NR-1:0]    front_dest;
  flit_type_e       front_type;

  req_state_e       state, state_d;
  logic [NR-1:0]    lock_dest, lock_dest_d;
  logic [NR-1:0]    req;
  logic             grant;
  logic             err_d;

  flit_fifo #(
    .W     (DW + NR),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (IN_VALID),
    .wdata ({IN_DEST, IN_FLIT}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign IN_READY   = !fifo_full;
  assign front_flit = fifo_rdata[DW-1:0];
  assign front_dest = fifo_rdata[DW+NR-1:DW];
  assign front_type = flit_type_e'(front_flit[TMSB -: TYPE_W]);

  // NOTE: every signal is defaulted before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req         = '0;
    pop         = 1'b0;
    err_d       = 1'b0;
    state_d     = state;
    lock_dest_d = lock_dest;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (opens_packet(front_type)) begin
            req = front_dest;
          end else begin
            // Stray BODY/TAIL with no open packet: drop it and flag it.
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (!fifo_empty) req = lock_dest;
      end
      default: ;
    endcase

    // req never depends on GRT, so this AND cannot close a loop.
    grant = |(GRT & req);

    if (grant) begin
      pop = 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (front_type == FLIT_HEAD) begin
            state_d     = ST_LOCKED;
            lock_dest_d = req;
          end
        end
        ST_LOCKED: begin
          if (opens_packet(front_type)) err_d = 1'b1;
          if (closes_packet(front_type)) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign REQ = req;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      lock_dest <= '0;
      OUT_VALID <= 1'b0;
      OUT_FLIT  <= '0;
      OUT_PORT  <= '0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_d;
      lock_dest <= lock_dest_d;
      OUT_VALID <= grant;
      ERR       <= err_d;
      if (grant) begin
        OUT_FLIT <= front_flit;
        OUT_PORT <= req;
      end
    end
  end

endmodule

// File: tb/tb_input_requester.sv
// Directed bench for input_requester: inputs driven and outputs sampled on
// the falling edge, expectations hand-derived.
module tb_input_requester;

  localparam int NR = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_FLIT;
  logic [NR-1:0] IN_DEST;
  logic [NR-1:0] REQ;
  logic [NR-1:0] GRT;
  logic          OUT_VALID;
  logic [DW-1:0] OUT_FLIT;
  logic [NR-1:0] OUT_PORT;
  logic          ERR;

  int checks = 0;
  int failures = 0;

  input_requester #(.NR(NR), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_FLIT   (IN_FLIT),
    .IN_DEST   (IN_DEST),
    .REQ       (REQ),
    .GRT       (GRT),
    .OUT_VALID (OUT_VALID),
    .OUT_FLIT  (OUT_FLIT),
    .OUT_PORT  (OUT_PORT),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic drive(input logic [DW-1:0] f, input logic [NR-1:0] d);
    IN_VALID = 1'b1;
    IN_FLIT  = f;
    IN_DEST  = d;
  endtask

  task automatic no_push();
    IN_VALID = 1'b0;
    IN_FLIT  = '0;
    IN_DEST  = '0;
  endtask

  logic [DW-1:0] pkt [4];

  initial begin
    RSTn = 1'b0;
    GRT  = '0;
    no_push();
    step();
    step();

    // Reset state
    check("rst_req", REQ, 5'b0);
    check("rst_ovalid", OUT_VALID, 1'b0);
    check("rst_oflit", OUT_FLIT, 32'h0);
    check("rst_oport", OUT_PORT, 5'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_ready", IN_READY, 1'b1);
    RSTn = 1'b1;

    // SINGLE flit to port 2, granted in its request cycle
    drive(mk(T_SGL, 30'h11), 5'b00100);
    step();
    no_push();
    check("s_req", REQ, 5'b00100);
    GRT = 5'b00100;
    step();
    GRT = '0;
    check("s_ovalid", OUT_VALID, 1'b1);
    check("s_oport", OUT_PORT, 5'b00100);
    check("s_oflit", OUT_FLIT, mk(T_SGL, 30'h11));
    check("s_req_after", REQ, 5'b0);
    step();
    check("s_ovalid_drop", OUT_VALID, 1'b0);

    // HEAD/BODY/BODY/TAIL to port 1; body dests are junk the lock must ignore
    pkt[0] = mk(T_HEAD, 30'h100);
    pkt[1] = mk(T_BODY, 30'h101);
    pkt[2] = mk(T_BODY, 30'h102);
    pkt[3] = mk(T_TAIL, 30'h103);
    drive(pkt[0], 5'b00010);
    step();
    check("w_req_wait0", REQ, 5'b00010);
    drive(pkt[1], 5'b10000);
    step();
    check("w_req_wait1", REQ, 5'b00010);
    drive(pkt[2], 5'b00001);
    step();
    check("w_req_wait2", REQ, 5'b00010);
    check("w_ovalid_wait", OUT_VALID, 1'b0);
    drive(pkt[3], 5'b01000);
    step();
    no_push();
    check("w_full_ready", IN_READY, 1'b0);
    check("w_req_full", REQ, 5'b00010);
    GRT = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("w_ovalid%0d", i), OUT_VALID, 1'b1);
      check($sformatf("w_oflit%0d", i), OUT_FLIT, pkt[i]);
      check($sformatf("w_oport%0d", i), OUT_PORT, 5'b00010);
      check($sformatf("w_req%0d", i), REQ, (i < 3) ? 5'b00010 : 5'b00000);
    end
    GRT = '0;
    step();
    check("w_ovalid_end", OUT_VALID, 1'b0);

    // Fill with DEPTH singles to port 3; wrong-port grant while full
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("f_ready%0d", i), IN_READY, 1'b1);
      drive(mk(T_SGL, 30'(32'h200 + i)), 5'b01000);
      step();
    end
    no_push();
    check("f_ready_full", IN_READY, 1'b0);
    check("f_req", REQ, 5'b01000);
    GRT = 5'b00001;
    step();
    check("f_req_wronggrt", REQ, 5'b01000);
    check("f_ovalid_wronggrt", OUT_VALID, 1'b0);
    check("f_ready_wronggrt", IN_READY, 1'b0);
    GRT = 5'b01000;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check($sformatf("f_ovalid%0d", i), OUT_VALID, 1'b1);
      check($sformatf("f_oflit%0d", i), OUT_FLIT, mk(T_SGL, 30'(32'h200 + i)));
      check($sformatf("f_ready_pop%0d", i), IN_READY, 1'b1);
    end
    check("f_req_empty", REQ, 5'b0);
    GRT = '0;
    step();

    // Stray BODY in IDLE: dropped with a single ERR pulse
    drive(mk(T_BODY, 30'h300), 5'b00001);
    step();
    no_push();
    check("e_req_body", REQ, 5'b0);
    check("e_err_pre", ERR, 1'b0);
    step();
    check("e_err", ERR, 1'b1);
    check("e_ovalid", OUT_VALID, 1'b0);
    check("e_req_after", REQ, 5'b0);
    step();
    check("e_err_once", ERR, 1'b0);

    // SINGLE inside an open packet: forwarded, ERR, and the lock releases
    drive(mk(T_HEAD, 30'h400), 5'b00001);
    step();
    drive(mk(T_SGL, 30'h401), 5'b10000);
    step();
    no_push();
    GRT = 5'b00001;
    step();
    check("l_oflit_head", OUT_FLIT, mk(T_HEAD, 30'h400));
    check("l_err_head", ERR, 1'b0);
    step();
    GRT = '0;
    check("l_oflit_sgl", OUT_FLIT, mk(T_SGL, 30'h401));
    check("l_oport_sgl", OUT_PORT, 5'b00001);
    check("l_err_sgl", ERR, 1'b1);
    drive(mk(T_SGL, 30'h402), 5'b00100);
    step();
    no_push();
    check("l_req_idle", REQ, 5'b00100);
    GRT = 5'b00100;
    step();
    GRT = '0;
    check("l_oflit_next", OUT_FLIT, mk(T_SGL, 30'h402));
    step();

    // Reset while LOCKED with two flits still buffered
    drive(mk(T_HEAD, 30'h500), 5'b10000);
    step();
    drive(mk(T_BODY, 30'h501), 5'b00001);
    step();
    drive(mk(T_BODY, 30'h502), 5'b00001);
    step();
    no_push();
    GRT = 5'b10000;
    step();
    GRT = '0;
    check("r_ovalid_pre", OUT_VALID, 1'b1);
    check("r_req_locked", REQ, 5'b10000);
    RSTn = 1'b0;
    step();
    check("r_req", REQ, 5'b0);
    check("r_ovalid", OUT_VALID, 1'b0);
    check("r_oflit", OUT_FLIT, 32'h0);
    check("r_oport", OUT_PORT, 5'b0);
    check("r_err", ERR, 1'b0);
    check("r_ready", IN_READY, 1'b1);
    RSTn = 1'b1;
    drive(mk(T_HEAD, 30'h600), 5'b00001);
    step();
    no_push();
    check("r_req_newhead", REQ, 5'b00001);
    GRT = 5'b00001;
    step();
    GRT = '0;
    check("r_ovalid_new", OUT_VALID, 1'b1);
    check("r_oflit_new", OUT_FLIT, mk(T_HEAD, 30'h600));
    check("r_req_locked_empty", REQ, 5'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_requester.md
# input_requester

Per-input-port request generator for the router's switch allocation stage; it is the requester end of the REQ/GRT interface served by the per-output fixed-priority arbiter. It buffers incoming flits, raises a one-hot request toward the output port chosen by route computation, and pops and forwards one flit per grant. Wormhole ordering is tracked per packet: after a head flit is granted, the port is locked to that output until the tail leaves.

## Interface
- NR, 5: number of output ports; width of REQ/GRT/destination vectors
- DW, 32: flit width in bits, type field included
- DEPTH, 4: input FIFO depth in flits; power of two, ≥2
- CLK  in  1  clock, rising edge
- RSTn  in  1  synchronous, active-low reset
- IN_VALID  in  1  upstream flit valid
- IN_READY  out  1  FIFO can accept; equals !full
- IN_FLIT  in  DW  flit; bits [DW-1:DW-2] are the type field
- IN_DEST  in  NR  one-hot output port from route computation; sampled with every flit, meaningful only on head flits
- REQ  out  NR  one-hot request to the output arbiters
- GRT  in  NR  grant vector from the output arbiters
- OUT_VALID  out  1  registered flit valid toward the crossbar
- OUT_FLIT  out  DW  registered granted flit
- OUT_PORT  out  NR  registered one-hot output port of OUT_FLIT
- ERR  out  1  one-cycle pulse on a protocol violation

## Operation
- Flit type field: 2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 SINGLE (head and tail).
- FIFO entries hold {IN_DEST, IN_FLIT}.
- Push when IN_VALID && IN_READY.
- The FIFO has DEPTH entries with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
- IN_READY is low whenever the FIFO is full, including in a cycle where a pop also occurs.
- State IDLE:
  - Front entry is HEAD or SINGLE: REQ = front IN_DEST.
  - Front entry is BODY or TAIL: pop it without a request, pulse ERR, stay in IDLE.
  - FIFO empty: REQ = 0.
- State LOCKED:
  - REQ = LOCK_DEST while the FIFO is non-empty, else 0.
  - A HEAD or SINGLE entry at the front is still forwarded, and ERR pulses.
- Grant condition: (GRT & REQ) != 0. GRT bits outside REQ are ignored.
- On a grant, pop the front entry. Next cycle, OUT_VALID=1, OUT_FLIT=that flit, OUT_PORT=REQ.
- Transitions on a grant:
  - IDLE + HEAD: latch LOCK_DEST=REQ and go to LOCKED.
  - IDLE + SINGLE: stay in IDLE.
  - LOCKED + TAIL (or SINGLE): go to IDLE.
  - LOCKED + BODY: stay in LOCKED.
- REQ is combinational from the state and the FIFO front only, never from GRT. There is no combinational loop.
- At most one pop per cycle.
- Reset: FIFO empty, state IDLE, LOCK_DEST=0, REQ=0, OUT_VALID=0, OUT_FLIT=0, OUT_PORT=0, ERR=0, IN_READY=1 on the first cycle after reset. A reset mid-packet discards all buffered flits.

## Timing
- A flit pushed at edge t is visible at the FIFO front from cycle t+1, so REQ can assert in cycle t+1.
- A grant sampled at edge g gives OUT_VALID high during cycle g+1. Request-to-output latency is 1 cycle.
- Back-to-back grants give one flit per cycle. The FIFO sustains full throughput when DEPTH ≥ 2.
- Empty FIFO with a simultaneous push: no pop that cycle. The request appears the next cycle.
- ERR is registered and is high for exactly the cycle after the offending pop.
- OUT_VALID stays low in any cycle not preceded by a grant or an error-free pop.

## Structure
- Shared router package `router_pkg`:
  - flit type enum (BODY/HEAD/TAIL/SINGLE)
  - type-field position constants
  - state enum {IDLE, LOCKED}
- Sub-module `flit_fifo`: parameterised DW+NR wide, DEPTH deep synchronous FIFO with full/empty/count. The top level holds the FSM, REQ decode and output register.

## Test plan
- Reset, then a SINGLE flit with IN_DEST=5'b00100 and GRT=5'b00100 in the REQ cycle:
  - REQ=00100 for one cycle.
  - Next cycle OUT_VALID=1, OUT_PORT=00100, then return to IDLE.
- HEAD, BODY, BODY, TAIL to port 5'b00010, with GRT withheld for 3 cycles and then held high:
  - REQ holds 00010 throughout.
  - The 4 flits are output on consecutive cycles.
  - REQ=0 after the tail.
- Push DEPTH flits without a grant:
  - IN_READY falls after the 4th push.
  - A grant while full pops one flit, and IN_READY returns the next cycle.
- BODY flit at the front in IDLE: popped, ERR pulses once, REQ stays 0, OUT_VALID stays 0.
- GRT=5'b00001 while REQ=5'b01000: no pop, REQ unchanged.
- Assert RSTn=0 mid-packet in LOCKED with 2 buffered flits:
  - Next cycle all outputs are 0 and IN_READY=1.
  - A new HEAD is requested normally.
